// File: rtl/data_mem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Byte lanes are little-endian: lane n holds bits [8n+7:8n] of a RAM word.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } resp_state_t;

  function automatic logic misaligned(mem_size_t sz, logic [1:0] off);
    case (sz)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(mem_size_t sz, logic [1:0] off);
    case (sz)
      SZ_B:    lane_mask = 4'b0001 << off;
      SZ_H:    lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] steer_wdata(logic [31:0] wd, logic [1:0] off);
    steer_wdata = wd << {off, 3'b000};
  endfunction

  function automatic logic [31:0] extend_load(logic [31:0] word, mem_size_t sz,
                                              logic [1:0] off, logic uns);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (sz)
      SZ_B:    extend_load = {{24{~uns & s[7]}}, s[7:0]};
      SZ_H:    extend_load = {{16{~uns & s[15]}}, s[15:0]};
      default: extend_load = s;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_resp_mem_bank.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module mem_bank #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// Load/store responder: one request at a time, access committed on the edge into RESP,
// response held until taken. The read register only updates on a load commit, so data is stable in RESP.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  resp_state_t              state_q;
  logic [CW-1:0]            cnt_q;
  logic                     we_q, uns_q, err_q, ld_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  mem_size_t                size_q;
  logic [DATA_WIDTH-1:0]    wdata_q;

  logic                     in_idle, commit, a_we, a_bad;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  mem_size_t                a_size;
  logic [DATA_WIDTH-1:0]    a_wdata;
  logic [3:0]               bank_we;
  logic                     bank_re;
  logic [31:0]              bank_rdata;

  // With LATENCY=1 the access happens on the accept edge, so it must use the live request.
  assign in_idle = (state_q == IDLE);
  assign a_we    = in_idle ? req_we : we_q;
  assign a_addr  = in_idle ? req_addr : addr_q;
  assign a_size  = in_idle ? mem_size_t'(req_size) : size_q;
  assign a_wdata = in_idle ? req_wdata : wdata_q;
  assign a_bad   = misaligned(a_size, a_addr[1:0]);

  assign commit  = (in_idle && req_valid && (LATENCY == 1)) ||
                   ((state_q == WAIT) && (cnt_q == CW'(1)));
  assign bank_we = (commit && a_we && !a_bad) ? lane_mask(a_size, a_addr[1:0]) : 4'b0000;
  assign bank_re = commit && !a_we && !a_bad;

  mem_bank #(.AW(ADDRESS_WIDTH - 2)) u_bank (
    .clk     (clk),
    .we_i    (bank_we),
    .re_i    (bank_re),
    .addr_i  (a_addr[ADDRESS_WIDTH-1:2]),
    .wdata_i (steer_wdata(a_wdata, a_addr[1:0])),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_B;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      if (commit) begin
        err_q <= a_bad;
        ld_q  <= !a_we && !a_bad;
      end
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          size_q  <= mem_size_t'(req_size);
          wdata_q <= req_wdata;
          cnt_q   <= CW'(LATENCY - 1);
          state_q <= (LATENCY > 1) ? WAIT : RESP;
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= RESP;
        end
        RESP: if (rsp_ready) begin
          state_q <= IDLE;
          err_q   <= 1'b0;
          ld_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = in_idle;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = ld_q ? extend_load(bank_rdata, size_q, addr_q[1:0], uns_q) : '0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: a LATENCY=2 and a LATENCY=1 instance checked against a byte-array memory model.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, rsp_err;
  logic        req_we = 1'b0, req_unsigned = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0][31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl   [2][256];
  bit         known [2][256];
  int         lat_exp [2] = '{2, 1};
  logic [31:0] last_rd;
  logic        last_err;

  always #5 clk = ~clk;

  data_mem_resp #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_resp #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  // Issue one request on instance d and wait (bounded) for its response; lat counts cycles from accept.
  task automatic txn(input int d, input logic we, input logic [7:0] a, input logic [1:0] sz,
                     input logic u, input logic [31:0] wd, output int lat);
    @(negedge clk);
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle dut%0d: got %b want 1", d, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid[d] = 1'b0;
      lat++;
    end while (rsp_valid[d] !== 1'b1 && lat < 20);
    last_rd  = rsp_rdata[d];
    last_err = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  // Transaction checked against the model: latency, error flag, and read data when all bytes are known.
  task automatic check_txn(input int d, input logic we, input logic [7:0] a, input logic [1:0] sz,
                           input logic u, input logic [31:0] wd, input string nm);
    int lat, n;
    bit bad, kn;
    logic [63:0] v;
    logic [31:0] exp_rd;
    txn(d, we, a, sz, u, wd, lat);
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    checks++;
    if (lat != lat_exp[d]) begin
      errors++;
      $display("FAIL %s latency dut%0d: got %0d want %0d", nm, d, lat, lat_exp[d]);
    end
    checks++;
    if (last_err !== bad) begin
      errors++;
      $display("FAIL %s err dut%0d: got %b want %b", nm, d, last_err, bad);
    end
    kn = 1'b1;
    exp_rd = 32'h0;
    if (bad || we) begin
      if (!bad) for (int i = 0; i < n; i++) begin
        mdl[d][a + i]   = wd[8*i +: 8];
        known[d][a + i] = 1'b1;
      end
    end else begin
      v = 64'h0;
      for (int i = 0; i < n; i++) begin
        v = v | (64'(mdl[d][a + i]) << (8 * i));
        if (!known[d][a + i]) kn = 1'b0;
      end
      if (!u && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      exp_rd = v[31:0];
    end
    if (kn) begin
      checks++;
      if (last_rd !== exp_rd) begin
        errors++;
        $display("FAIL %s rdata dut%0d: got %h want %h", nm, d, last_rd, exp_rd);
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 2'b11 || rsp_valid !== 2'b00 || rsp_err !== 2'b00 ||
        rsp_rdata[0] !== 32'h0 || rsp_rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rd0=%h rd1=%h want 11 00 00 0 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata[0], rsp_rdata[1]);
    end
  endtask

  task automatic test_directed;
    check_txn(0, 1, 8'h10, 2'd2, 0, 32'hDEADBEEF, "st_w_10");
    check_txn(0, 0, 8'h10, 2'd2, 0, 32'h0, "ld_w_10");
    checks++;
    if (last_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_w_10_const: got %h want deadbeef", last_rd); end
    check_txn(0, 0, 8'h13, 2'd0, 0, 32'h0, "ld_b_13_s");
    checks++;
    if (last_rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL ld_b_13_s_const: got %h want ffffffde", last_rd); end
    check_txn(0, 0, 8'h13, 2'd0, 1, 32'h0, "ld_b_13_u");
    check_txn(0, 0, 8'h12, 2'd1, 0, 32'h0, "ld_h_12_s");
    checks++;
    if (last_rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL ld_h_12_s_const: got %h want ffffdead", last_rd); end
    check_txn(0, 1, 8'h11, 2'd0, 0, 32'hAAAAAA55, "st_b_11");
    check_txn(0, 0, 8'h10, 2'd2, 0, 32'h0, "ld_w_10_after_b");
    checks++;
    if (last_rd !== 32'hDEAD55EF) begin errors++; $display("FAIL ld_w_10_lane1: got %h want dead55ef", last_rd); end
    check_txn(1, 1, 8'h08, 2'd1, 0, 32'h0000F00D, "l1_st_h_08");
    check_txn(1, 0, 8'h08, 2'd1, 1, 32'h0, "l1_ld_h_08_u");
  endtask

  task automatic test_errors;
    check_txn(0, 0, 8'h11, 2'd1, 0, 32'h0, "ld_h_11_mis");
    check_txn(0, 1, 8'h12, 2'd2, 0, 32'h11223344, "st_w_12_mis");
    check_txn(0, 0, 8'h10, 2'd2, 0, 32'h0, "ld_w_10_unchanged");
    check_txn(0, 0, 8'h10, 2'd3, 0, 32'h0, "ld_size11");
    check_txn(0, 1, 8'h14, 2'd3, 0, 32'h12345678, "st_size11");
  endtask

  task automatic test_stall;
    logic [31:0] held;
    int lat;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'hBAD0BAD0;
    checks++;
    if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL stall_ready_wait: got %b want 0", req_ready[0]); end
    lat = 0;
    while (rsp_valid[0] !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    checks++;
    if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL stall_rsp_timeout: got valid=%b want 1", rsp_valid[0]); end
    held = rsp_rdata[0];
    checks++;
    if (held !== {mdl[0][8'h13], mdl[0][8'h12], mdl[0][8'h11], mdl[0][8'h10]}) begin
      errors++;
      $display("FAIL stall_rdata: got %h want %h", held, {mdl[0][8'h13], mdl[0][8'h12], mdl[0][8'h11], mdl[0][8'h10]});
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== held || req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b rd=%h ready=%b want 1 %h 0",
                 rsp_valid[0], rsp_rdata[0], req_ready[0], held);
      end
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    repeat (2) begin
      checks++;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL stall_release: got valid=%b ready=%b want 0 1", rsp_valid[0], req_ready[0]);
      end
      @(negedge clk);
    end
    check_txn(0, 0, 8'h10, 2'd2, 0, 32'h0, "ld_after_stall");
  endtask

  task automatic test_reset_mid;
    check_txn(0, 1, 8'h20, 2'd2, 0, 32'h0, "st_w_20_zero");
    @(negedge clk);
    req_valid[0] = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_size = 2'd2; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_err[0] !== 1'b0 || rsp_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got ready=%b valid=%b err=%b rd=%h want 1 0 0 0",
               req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_no_rsp: got valid=%b want 0", rsp_valid[0]); end
    end
    check_txn(0, 0, 8'h20, 2'd2, 0, 32'h0, "ld_w_20_after_rst");
  endtask

  task automatic test_random;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 8; w++) check_txn(d, 1, 8'h40 + 8'(4 * w), 2'd2, 0, $urandom, "rnd_fill");
      for (int k = 0; k < 30; k++) begin
        check_txn(d, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 31)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, "rnd");
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_reset;
    test_directed;
    test_errors;
    test_stall;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Memory-side responder for the CPU's load/store port: accepts one request at a time over a valid/ready handshake and performs the byte, half or word access against an internal little-endian RAM. It returns read data (sign- or zero-extended) or a write acknowledgement after a fixed, parameterised latency. It is the target end of the CPU data-memory interface and also serves as a latency-injecting memory model for CPU-level benches.

## Interface
- DATA_WIDTH, 32, data bus width; fixed at 32 (four byte lanes)
- ADDRESS_WIDTH, 8, byte-address width; RAM holds 2**ADDRESS_WIDTH bytes; must be ≥ 2
- LATENCY, 2, cycles from request acceptance to rsp_valid; must be ≥ 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDRESS_WIDTH  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only; 1 = zero-extend, 0 = sign-extend
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes response
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, capture we/addr/size/unsigned/wdata, load the counter with LATENCY-1, then:
  - go to WAIT if LATENCY>1;
  - otherwise perform the access on the next edge and go to RESP.
- WAIT: counter decrements each cycle. At the edge where counter==1, the access is performed and the state goes to RESP. rsp_valid is first high LATENCY cycles after the accept edge.
- Access:
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=00; size 11 is illegal.
  - Any failure: rsp_err=1, no write, rsp_rdata=0.
  - Store: writes only the addressed byte lanes (little-endian, lane = addr[1:0]) from the right-aligned req_wdata; rsp_rdata=0.
  - Load: selects the lane(s), then sign- or zero-extends to 32 bits.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- No request is accepted while in WAIT or RESP. Minimum occupancy is LATENCY+1 cycles per transaction.
- RAM contents are not reset. A read of unwritten memory returns X in simulation and is not checked.

## Timing
- Reset (rst low, asynchronous): state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-operation: pending request is dropped. A store whose commit edge has not occurred is not written. No response is issued after reset release.
- The store commit edge is the transition into RESP. A load issued after a store's response has been taken observes the new data.
- The address space has no wrap-around: aligned accesses never cross the top address, and misaligned accesses are rejected.
- rsp_ready high before rsp_valid has no effect. rsp_ready asserted in the same cycle rsp_valid rises completes the handshake in that cycle.
- req_* inputs are don't-care outside IDLE.

## Structure
- Package data_mem_pkg holds:
  - enum mem_size_t (SZ_B, SZ_H, SZ_W, SZ_BAD);
  - enum resp_state_t (IDLE, WAIT, RESP);
  - byte-lane mask and extension helper functions.
- Sub-module mem_bank: a 2**(ADDRESS_WIDTH-2) × 32 synchronous RAM with four byte-write enables and a registered read port. data_mem_resp contains the FSM, counter, alignment check, lane steering and extension.

## Test plan
- LATENCY=2, reset, then store word 0xDEADBEEF at 0x10 (accept at cycle T) -> rsp_valid high at T+2 with rsp_err=0 and rsp_rdata=0; word load at 0x10 -> 0xDEADBEEF.
- After that store: byte load at 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; half load at 0x12 signed -> 0xFFFFDEAD.
- Byte store 0x55 at 0x11, then word load at 0x10 -> 0xDEAD55EF (only lane 1 changed).
- Half load at 0x11 -> rsp_err=1, rsp_rdata=0; word store at 0x12 -> rsp_err=1 and a later word load at 0x10 is unchanged; req_size=11 -> rsp_err=1.
- Hold rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; req_valid pulses during WAIT and RESP are ignored.
- Assert rst during WAIT of a word store 0x12345678 to 0x20 (previously 0) -> all outputs at reset values immediately; after release a load of 0x20 returns 0. LATENCY=1 variant -> rsp_valid at T+1.
